// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: FIFO-buffered command issue to a combinational ALU with valid/ready result return
module alu_cmd_sequencer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_s,
    input  logic [WIDTH-1:0] alu_y,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [1:0]       rsp_op,
    output logic             rsp_zero,
    output logic             busy
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
    state_t           state;
    logic [WIDTH-1:0] fa [DEPTH];
    logic [WIDTH-1:0] fb [DEPTH];
    logic [1:0]       fs [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             push, pop;
    assign cmd_ready = count != (AW+1)'(DEPTH);
    assign push      = cmd_valid & cmd_ready;
    assign pop       = count != '0 && (state == IDLE || (state == RESP && rsp_ready));
    assign busy      = state != IDLE || count != '0;
    always_ff @(posedge clk) begin
        if (push) begin
            fa[wr_ptr] <= cmd_a;
            fb[wr_ptr] <= cmd_b;
            fs[wr_ptr] <= cmd_op;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_s     <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_op    <= '0;
            rsp_zero  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                alu_a  <= fa[rd_ptr];
                alu_b  <= fb[rd_ptr];
                alu_s  <= fs[rd_ptr];
            end
            if (push != pop) count <= push ? count + 1'b1 : count - 1'b1;
            case (state)
                IDLE:  if (pop) state <= ISSUE;
                ISSUE: begin
                    rsp_data  <= alu_y;
                    rsp_op    <= alu_s;
                    rsp_zero  <= alu_y == '0;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    state     <= pop ? ISSUE : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: scoreboard bench driving directed and random commands through a modelled ALU
module tb_alu_cmd_sequencer;
    logic        clk = 0, rst = 1;
    logic        cmd_valid = 0, cmd_ready;
    logic [1:0]  cmd_op = 0;
    logic [31:0] cmd_a = 0, cmd_b = 0;
    logic [31:0] alu_a, alu_b, alu_y;
    logic [1:0]  alu_s;
    logic        rsp_valid, rsp_ready = 0;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_op;
    logic        rsp_zero, busy;
    int          checks = 0, failures = 0;
    typedef struct {logic [31:0] d; logic [1:0] op;} exp_t;
    exp_t        sb[$];
    alu_cmd_sequencer #(.WIDTH(32), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_y(alu_y),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_op(rsp_op), .rsp_zero(rsp_zero), .busy(busy)
    );
    always #5 clk = ~clk;
    function automatic logic [31:0] alu(input logic [1:0] s, input logic [31:0] a, b);
        return s == 2'b00 ? a + b : s == 2'b01 ? a - b : s == 2'b10 ? a & b : a | b;
    endfunction
    assign alu_y = alu(alu_s, alu_a, alu_b);
    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask
    // Monitor: transfers are judged at the negedge before the accepting edge
    logic        stall = 0;
    logic [31:0] pd;
    logic [1:0]  po;
    always @(negedge clk) begin
        exp_t e;
        if (rst) stall = 0;
        else begin
            if (stall) begin
                chk("stall_valid", 32'(rsp_valid), 1);
                chk("stall_data", rsp_data, pd);
                chk("stall_op", 32'(rsp_op), 32'(po));
            end
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_rsp: got %h expected none", rsp_data);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_data", rsp_data, e.d);
                    chk("rsp_op", 32'(rsp_op), 32'(e.op));
                    chk("rsp_zero", 32'(rsp_zero), 32'(e.d == 0));
                end
            end
            stall = rsp_valid && !rsp_ready;
            pd = rsp_data;
            po = rsp_op;
        end
    end
    task automatic send(input logic [1:0] op, input logic [31:0] a, b, input logic [31:0] e);
        int n = 0;
        logic ok;
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_valid = 1;
        do begin
            @(negedge clk) ok = cmd_ready;
            @(posedge clk) n++;
        end while (!ok && n < 500);
        if (ok) sb.push_back('{e, op});
        else chk("send_timeout", 0, 1);
        #1 cmd_valid = 0;
    endtask
    task automatic drain();
        int n = 0;
        rsp_ready = 1;
        while ((sb.size() != 0 || busy) && n < 500) begin
            @(posedge clk) #1;
            n++;
        end
        chk("drain_empty", 32'(sb.size()), 0);
        chk("drain_idle", 32'(busy), 0);
    endtask
    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
    initial begin
        int acc;
        logic [1:0] op;
        logic [31:0] a, b;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        chk("rst_cmd_ready", 32'(cmd_ready), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_alu_a", alu_a, 0);
        rsp_ready = 1;
        // ADD with latency check
        send(2'b00, 5, 7, 12);
        @(posedge clk) #1 chk("lat_t1", 32'(rsp_valid), 0);
        @(posedge clk) #1 chk("lat_t2", 32'(rsp_valid), 1);
        chk("add_data", rsp_data, 12);
        drain();
        send(2'b01, 9, 9, 0);
        send(2'b01, 0, 1, 32'hFFFF_FFFF);
        send(2'b10, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000);
        send(2'b11, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0);
        drain();
        // Fill: one command in the ALU regs plus DEPTH queued
        rsp_ready = 0;
        acc = 0;
        cmd_valid = 1;
        for (int i = 0; i < 6; i++) begin
            cmd_op = 2'(i); cmd_a = 32'(100 + i); cmd_b = 32'(i);
            @(negedge clk);
            if (cmd_ready) begin
                acc++;
                sb.push_back('{alu(cmd_op, cmd_a, cmd_b), cmd_op});
            end
            @(posedge clk) #1;
        end
        cmd_valid = 0;
        chk("fill_accepted", 32'(acc), 5);
        chk("fill_cmd_ready", 32'(cmd_ready), 0);
        drain();
        // Reset in the middle of a stalled response with 3 queued
        rsp_ready = 0;
        for (int i = 0; i < 4; i++) send(2'b00, 32'(i), 1, 32'(i + 1));
        chk("pre_rst_valid", 32'(rsp_valid), 1);
        #2 rst = 1;
        #1 sb.delete();
        chk("mid_rst_valid", 32'(rsp_valid), 0);
        chk("mid_rst_alu_a", alu_a, 0);
        chk("mid_rst_alu_b", alu_b, 0);
        chk("mid_rst_alu_s", 32'(alu_s), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        @(posedge clk) #1 rst = 0;
        rsp_ready = 1;
        repeat (10) @(posedge clk);
        #1 chk("post_rst_busy", 32'(busy), 0);
        chk("post_rst_cmd_ready", 32'(cmd_ready), 1);
        // Random traffic under random backpressure
        fork
            begin
                for (int i = 0; i < 50; i++) begin
                    op = 2'($urandom_range(0, 3));
                    a = $urandom;
                    b = (i % 7 == 0) ? a : $urandom;
                    send(op, a, b, alu(op, a, b));
                end
            end
            begin
                for (int i = 0; i < 400 && (sb.size() != 0 || busy || i < 20); i++) begin
                    @(posedge clk) #1 rsp_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
